// File: rtl/game_pkg.sv
// Shared game-state definitions: FSM encoding, screen timing limits and
// the fixed bird/floor geometry used by the collision and score logic.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2
  } game_state_e;

  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_LAST  = 10'd524;
  localparam logic [9:0] BIRD_X  = 10'd200;
  localparam logic [9:0] FLOOR_Y = 10'd448;

  localparam int BCD_DIGITS  = 4;
  localparam int SCORE_W     = 4 * BCD_DIGITS;

endpackage

// File: rtl/bcd_score_counter.sv
// Packed-BCD score register: synchronous clear, single-step increment,
// saturating at all nines.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {BCD_DIGITS{4'h9}};

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] inc_val;
  logic [BCD_DIGITS:0] carry;

  assign carry[0] = 1'b1;

  // Ripple the +1 through the digits; a 9 rolls to 0 and carries onward.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig            = score_q[4*gi +: 4];
    assign carry[gi+1]    = carry[gi] && (dig == 4'd9);
    assign inc_val[4*gi +: 4] = !carry[gi]    ? dig   :
                                (dig == 4'd9) ? 4'd0  :
                                                dig + 4'd1;
  end

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (inc && (score_q != SCORE_MAX)) begin
      score_d = inc_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/collision_score_ctrl.sv
// Game-state controller: detects bird/pipe overlap and floor/ceiling hits,
// counts passed pipes and runs the IDLE/PLAYING/DEAD state machine.
module collision_score_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] CEIL_Y      = 10'd0,
  parameter int         DEAD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        bird_pixel,
  input  logic        pipe_pixel,
  input  logic [9:0]  bird_y,
  input  logic [9:0]  pipe_right_x,
  output logic        game_active,
  output logic        game_over,
  output logic [15:0] score
);

  localparam int DW = $clog2(DEAD_FRAMES + 1);

  game_state_e state_q, state_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic          hit_latch_q, hit_latch_d;
  logic          button_q;
  logic [9:0]    prev_pipe_right_x_q, prev_pipe_right_x_d;
  logic          game_active_q, game_over_q;

  logic frame_end;
  logic press;
  logic hit_now;
  logic hit_seen;
  logic crash;
  logic pipe_passed;
  logic score_clear;
  logic score_inc;

  assign frame_end = (hCount == H_LAST) && (vCount == V_LAST);
  assign press     = button && !button_q;
  assign hit_now   = bright && bird_pixel && pipe_pixel;
  // A hit landing on the frame_end cycle still belongs to the closing frame.
  assign hit_seen  = hit_latch_q || hit_now;
  assign crash     = hit_seen || (bird_y >= FLOOR_Y) || (bird_y <= CEIL_Y);

  // Only a right edge crossing leftwards past the bird scores; a respawn
  // jumping from small to large can never satisfy both terms.
  assign pipe_passed = (prev_pipe_right_x_q >= BIRD_X) && (pipe_right_x < BIRD_X);

  assign prev_pipe_right_x_d = frame_end ? pipe_right_x : prev_pipe_right_x_q;

  always_comb begin
    state_d     = state_q;
    dead_cnt_d  = dead_cnt_q;
    hit_latch_d = 1'b0;
    score_clear = 1'b0;
    score_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          score_clear = 1'b1;
          state_d     = PLAYING;
        end
      end
      PLAYING: begin
        hit_latch_d = hit_seen;
        if (frame_end) begin
          hit_latch_d = 1'b0;
          if (crash) begin
            state_d    = DEAD;
            dead_cnt_d = DW'(DEAD_FRAMES);
          end else if (pipe_passed) begin
            score_inc = 1'b1;
          end
        end
      end
      DEAD: begin
        if (frame_end && (dead_cnt_q != '0)) begin
          dead_cnt_d = dead_cnt_q - DW'(1);
        end
        // Presses during the lockout are dropped, not queued.
        if (press && (dead_cnt_q == '0)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      dead_cnt_q          <= '0;
      hit_latch_q         <= 1'b0;
      button_q            <= 1'b0;
      prev_pipe_right_x_q <= '0;
      game_active_q       <= 1'b0;
      game_over_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      dead_cnt_q          <= dead_cnt_d;
      hit_latch_q         <= hit_latch_d;
      button_q            <= button;
      prev_pipe_right_x_q <= prev_pipe_right_x_d;
      game_active_q       <= (state_d == PLAYING);
      game_over_q         <= (state_d == DEAD);
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .score (score)
  );

  assign game_active = game_active_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_collision_score_ctrl.sv
// Bench for collision_score_ctrl: directed scenarios plus randomized play,
// all checked against a decimal-score game model kept here.
module tb_collision_score_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        button;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bird_pixel;
  logic        pipe_pixel;
  logic [9:0]  bird_y;
  logic [9:0]  pipe_right_x;
  logic        game_active;
  logic        game_over;
  logic [15:0] score;

  int checks = 0;
  int passes = 0;

  // Behavioural model: mode 0 waiting, 1 in play, 2 crashed; score kept as a plain integer.
  int m_mode, m_score, m_dead, m_prev_pipe;
  bit m_hit, m_btn_prev;

  always #5 clk = ~clk;

  collision_score_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .bright       (bright),
    .hCount       (hCount),
    .vCount       (vCount),
    .bird_pixel   (bird_pixel),
    .pipe_pixel   (pipe_pixel),
    .bird_y       (bird_y),
    .pipe_right_x (pipe_right_x),
    .game_active  (game_active),
    .game_over    (game_over),
    .score        (score)
  );

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic exp_active();
    return m_mode == 1;
  endfunction

  function automatic logic exp_over();
    return m_mode == 2;
  endfunction

  task automatic model_step();
    bit fe, pr, crashed;
    int old_dead;
    fe = (hCount == 10'd799) && (vCount == 10'd524);
    pr = button && !m_btn_prev;
    if (reset) begin
      m_mode = 0; m_score = 0; m_dead = 0; m_prev_pipe = 0; m_hit = 0; m_btn_prev = 0;
      return;
    end
    if (m_mode == 0) begin
      if (pr) begin
        m_score = 0;
        m_mode  = 1;
      end
    end else if (m_mode == 1) begin
      crashed = m_hit || (bright && bird_pixel && pipe_pixel);
      m_hit   = crashed;
      if (fe) begin
        if (crashed || int'(bird_y) >= 448 || int'(bird_y) <= 0) begin
          m_mode = 2;
          m_dead = 60;
        end else if (m_prev_pipe >= 200 && int'(pipe_right_x) < 200 && m_score < 9999) begin
          m_score++;
        end
        m_hit = 0;
      end
    end else begin
      old_dead = m_dead;
      m_hit    = 0;
      if (fe && m_dead > 0) m_dead--;
      if (pr && old_dead == 0) m_mode = 0;
    end
    if (fe) m_prev_pipe = int'(pipe_right_x);
    m_btn_prev = button;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit fe);
    hCount = fe ? 10'd799 : 10'd10;
    vCount = fe ? 10'd524 : 10'd20;
  endtask

  task automatic frame_end_with_pipe(input int px);
    pipe_right_x = 10'(px);
    set_line(1'b1);
    tick();
    set_line(1'b0);
  endtask

  task automatic do_press();
    button = 1'b1;
    tick();
    button = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; button = 0; bright = 0; bird_pixel = 0; pipe_pixel = 0;
    bird_y = 10'd100; pipe_right_x = 10'd0; set_line(1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (game_active !== 1'b0) $display("FAIL reset_active got=%b exp=0", game_active); else passes++;
    checks++; if (game_over !== 1'b0) $display("FAIL reset_over got=%b exp=0", game_over); else passes++;
    checks++; if (score !== 16'h0000) $display("FAIL reset_score got=%h exp=0000", score); else passes++;
  endtask

  task automatic test_start();
    button = 1'b1;
    tick();
    checks++; if (game_active !== 1'b1) $display("FAIL start_active got=%b exp=1", game_active); else passes++;
    checks++; if (score !== 16'h0000) $display("FAIL start_score got=%h exp=0000", score); else passes++;
    button = 1'b0;
    tick();
  endtask

  task automatic test_pass_and_wrap();
    frame_end_with_pipe(201);
    tick();
    frame_end_with_pipe(199);
    checks++; if (score !== 16'h0001) $display("FAIL pass_score got=%h exp=0001", score); else passes++;
    tick();
    frame_end_with_pipe(640);
    checks++; if (score !== 16'h0001) $display("FAIL wrap_score got=%h exp=0001", score); else passes++;
    checks++; if (score !== to_bcd(m_score)) $display("FAIL wrap_model got=%h exp=%h", score, to_bcd(m_score)); else passes++;
  endtask

  task automatic test_hit_and_pass();
    frame_end_with_pipe(201);
    bright = 1; bird_pixel = 1; pipe_pixel = 1;
    tick();
    bright = 0; bird_pixel = 0; pipe_pixel = 0;
    tick();
    frame_end_with_pipe(199);
    checks++; if (game_over !== 1'b1) $display("FAIL hit_over got=%b exp=1", game_over); else passes++;
    checks++; if (game_active !== 1'b0) $display("FAIL hit_active got=%b exp=0", game_active); else passes++;
    checks++; if (score !== 16'h0001) $display("FAIL hit_score got=%h exp=0001", score); else passes++;
  endtask

  task automatic run_lockout();
    for (int i = 0; i < 30; i++) frame_end_with_pipe(300);
    do_press();
    checks++; if (game_over !== 1'b1) $display("FAIL lock30_over got=%b exp=1", game_over); else passes++;
    for (int i = 0; i < 29; i++) frame_end_with_pipe(300);
    do_press();
    checks++; if (game_over !== 1'b1) $display("FAIL lock59_over got=%b exp=1", game_over); else passes++;
    frame_end_with_pipe(300);
    do_press();
    checks++; if (game_over !== 1'b0) $display("FAIL lock60_over got=%b exp=0", game_over); else passes++;
    checks++; if (game_active !== 1'b0) $display("FAIL lock60_active got=%b exp=0", game_active); else passes++;
  endtask

  task automatic test_floor_death();
    run_lockout();
    do_press();
    checks++; if (game_active !== 1'b1) $display("FAIL replay_active got=%b exp=1", game_active); else passes++;
    checks++; if (score !== 16'h0000) $display("FAIL replay_score got=%h exp=0000", score); else passes++;
    bird_y = 10'd448;
    frame_end_with_pipe(300);
    bird_y = 10'd100;
    checks++; if (game_over !== 1'b1) $display("FAIL floor_over got=%b exp=1", game_over); else passes++;
    run_lockout();
    do_press();
  endtask

  task automatic fast_passes(input int n);
    for (int i = 0; i < n; i++) begin
      frame_end_with_pipe(200);
      frame_end_with_pipe(199);
    end
  endtask

  task automatic test_bcd_carry();
    fast_passes(99);
    checks++; if (score !== 16'h0099) $display("FAIL bcd99 got=%h exp=0099", score); else passes++;
    fast_passes(1);
    checks++; if (score !== 16'h0100) $display("FAIL bcd100 got=%h exp=0100", score); else passes++;
  endtask

  task automatic test_saturation();
    fast_passes(9899);
    checks++; if (score !== 16'h9999) $display("FAIL sat_reach got=%h exp=9999", score); else passes++;
    fast_passes(2);
    checks++; if (score !== 16'h9999) $display("FAIL sat_hold got=%h exp=9999", score); else passes++;
    checks++; if (game_active !== 1'b1) $display("FAIL sat_active got=%b exp=1", game_active); else passes++;
  endtask

  task automatic test_bright_gate();
    bright = 0; bird_pixel = 1; pipe_pixel = 1;
    tick();
    frame_end_with_pipe(300);
    bird_pixel = 0; pipe_pixel = 0;
    checks++; if (game_active !== 1'b1) $display("FAIL dark_active got=%b exp=1", game_active); else passes++;
    checks++; if (game_over !== 1'b0) $display("FAIL dark_over got=%b exp=0", game_over); else passes++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (game_active !== 1'b0) $display("FAIL rstmid_active got=%b exp=0", game_active); else passes++;
    checks++; if (score !== 16'h0000) $display("FAIL rstmid_score got=%h exp=0000", score); else passes++;
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 4000; i++) begin
      set_line($urandom_range(0, 3) == 0);
      button     = ($urandom_range(0, 7) == 0);
      bright     = $urandom_range(0, 1) != 0;
      bird_pixel = ($urandom_range(0, 9) == 0);
      pipe_pixel = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      sel = int'($urandom_range(0, 19));
      bird_y = (sel == 0) ? 10'd448 : (sel == 1) ? 10'd0 : (sel == 2) ? 10'd447 :
               (sel == 3) ? 10'd1 : 10'd100;
      sel = int'($urandom_range(0, 9));
      pipe_right_x = (sel == 0) ? 10'd0 : (sel == 1) ? 10'd640 : 10'($urandom_range(195, 205));
      tick();
      checks++;
      if (game_active !== exp_active() || game_over !== exp_over() || score !== to_bcd(m_score)) begin
        $display("FAIL rand_cycle%0d got act=%b over=%b score=%h exp act=%b over=%b score=%h",
                 i, game_active, game_over, score, exp_active(), exp_over(), to_bcd(m_score));
      end else begin
        passes++;
      end
    end
    reset = 0; button = 0; bright = 0; bird_pixel = 0; pipe_pixel = 0; bird_y = 10'd100;
    set_line(1'b0);
    tick();
  endtask

  task automatic force_playing();
    for (int i = 0; i < 70 && m_mode != 1; i++) begin
      if (m_mode == 2) frame_end_with_pipe(300);
      if (m_mode != 1) do_press();
    end
    checks++; if (game_active !== 1'b1) $display("FAIL reenter_active got=%b exp=1", game_active); else passes++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_pass_and_wrap();
    test_hit_and_pass();
    test_floor_death();
    test_bcd_carry();
    test_saturation();
    test_bright_gate();
    test_random();
    force_playing();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
